mio_bus_responder: RTL and testbench

- Memory/IO responder on the CPU's MIO bus: the other end of the multicycle controller's MemRead/MemWrite/CPU_MIO request and MIO_ready handshake.
- Decodes the address, services RAM (synchronous block RAM port), a GPIO register and a cycle counter, then returns read data with a one-cycle MIO_ready pulse.
- Sits between the CPU datapath and the board memory/peripherals.

---
 rtl/mio_bus_responder_pkg.sv | 34 +++
 rtl/mio_bus_responder_if.sv | 27 ++
 rtl/mio_bus_responder_decode.sv | 28 ++
 rtl/mio_bus_responder.sv | 160 ++++++++++++++++
 tb/tb_mio_bus_responder.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mio_bus_responder_pkg.sv
// ============================================================================
// mio_pkg : shared encodings for the MIO bus responder
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_WAIT   = 3'd2,
    ST_READY  = 3'd3,
    ST_TURN   = 3'd4
  } state_t;

  localparam logic [3:0] REGION_RAM  = 4'h0;
  localparam logic [3:0] REGION_GPIO = 4'hE;
  localparam logic [3:0] REGION_CNT  = 4'hF;

  localparam logic [31:0] GPIO_BASE    = 32'hE000_0000;
  localparam logic [31:0] CNT_BASE     = 32'hF000_0000;
  localparam logic [31:0] ERR_CLR_ADDR = GPIO_BASE + 32'h4;

  typedef enum logic [1:0] {
    SEL_RAM  = 2'd0,
    SEL_GPIO = 2'd1,
    SEL_CNT  = 2'd2,
    SEL_NONE = 2'd3
  } sel_t;

endpackage

`default_nettype wire

// File: rtl/mio_bus_responder_if.sv
// ============================================================================
// mio_bus_if : CPU-side MIO request/response handshake
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mio_bus_if;
  logic        MemRead;
  logic        MemWrite;
  logic        CPU_MIO;
  logic [31:0] addr_bus;
  logic [31:0] data_from_CPU;
  logic [31:0] data_to_CPU;
  logic        MIO_ready;

  modport master (
    output MemRead, MemWrite, CPU_MIO, addr_bus, data_from_CPU,
    input  data_to_CPU, MIO_ready
  );

  modport slave (
    input  MemRead, MemWrite, CPU_MIO, addr_bus, data_from_CPU,
    output data_to_CPU, MIO_ready
  );
endinterface

`default_nettype wire

// File: rtl/mio_bus_responder_decode.sv
// ============================================================================
// mio_addr_decode : region select from addr[31:28] with unmapped flag
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mio_addr_decode
  import mio_pkg::*;
(
  input  logic [3:0] region,
  output sel_t       sel,
  output logic       unmapped
);

  always_comb begin
    sel      = SEL_NONE;
    unmapped = 1'b1;
    case (region)
      REGION_RAM:  begin sel = SEL_RAM;  unmapped = 1'b0; end
      REGION_GPIO: begin sel = SEL_GPIO; unmapped = 1'b0; end
      REGION_CNT:  begin sel = SEL_CNT;  unmapped = 1'b0; end
      default:     begin sel = SEL_NONE; unmapped = 1'b1; end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mio_bus_responder.sv
// ============================================================================
// mio_bus_responder : MIO bus responder for RAM, GPIO and cycle counter
// Optional: MIO_BUSERR_EN adds sticky bus_err / err_addr capture
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int RAM_AW  = 10,
  parameter int RAM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  mio_bus_if.slave          bus,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out
`ifdef MIO_BUSERR_EN
  ,
  output logic              bus_err,
  output logic [31:0]       err_addr
`endif
);

  localparam logic [3:0] WAIT_LAST = 4'(RAM_LAT - 2);

  state_t      state;
  logic [3:0]  wait_cnt;
  sel_t        sel_q;
  logic        wr_q;
  logic [31:0] wdata_q;
  logic [31:0] rd_hold;
  logic [31:0] cycle_cnt;

  sel_t        sel_d;
  logic        unmapped_d;
  logic        req;
  logic        unused_addr;

`ifdef MIO_BUSERR_EN
  logic        clr_q;
`endif

  assign req         = bus.CPU_MIO & (bus.MemRead | bus.MemWrite);
  assign unused_addr = ^bus.addr_bus;

  mio_addr_decode u_decode (
    .region   (bus.addr_bus[31:28]),
    .sel      (sel_d),
    .unmapped (unmapped_d)
  );

  // Free-running counter; a write in ACCESS replaces that cycle's increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= 32'h0;
    end else if (state == ST_ACCESS && wr_q && sel_q == SEL_CNT) begin
      cycle_cnt <= wdata_q;
    end else begin
      cycle_cnt <= cycle_cnt + 32'h1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      bus.MIO_ready   <= 1'b0;
      bus.data_to_CPU <= 32'h0;
      led_out         <= 16'h0;
      ram_en          <= 1'b0;
      ram_we          <= 1'b0;
      ram_addr        <= '0;
      ram_din         <= 32'h0;
      wait_cnt        <= 4'h0;
      sel_q           <= SEL_NONE;
      wr_q            <= 1'b0;
      wdata_q         <= 32'h0;
      rd_hold         <= 32'h0;
`ifdef MIO_BUSERR_EN
      bus_err         <= 1'b0;
      err_addr        <= 32'h0;
      clr_q           <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            state    <= ST_ACCESS;
            sel_q    <= sel_d;
            wr_q     <= bus.MemWrite;
            wdata_q  <= bus.data_from_CPU;
            ram_addr <= bus.addr_bus[RAM_AW+1:2];
            ram_din  <= bus.data_from_CPU;
            ram_en   <= (sel_d == SEL_RAM);
            ram_we   <= bus.MemWrite & (sel_d == SEL_RAM);
`ifdef MIO_BUSERR_EN
            clr_q    <= bus.MemWrite & (bus.addr_bus[31:2] == ERR_CLR_ADDR[31:2]);
            if (unmapped_d && !bus_err) begin
              bus_err  <= 1'b1;
              err_addr <= bus.addr_bus;
            end
`endif
          end
        end
        ST_ACCESS: begin
          state    <= ST_WAIT;
          ram_en   <= 1'b0;
          ram_we   <= 1'b0;
          wait_cnt <= 4'h0;
          if (wr_q && sel_q == SEL_GPIO) begin
            led_out <= wdata_q[15:0];
          end
          case (sel_q)
            SEL_CNT:  rd_hold <= cycle_cnt;
            SEL_GPIO: rd_hold <= {16'h0, sw_in};
            default:  rd_hold <= 32'h0;
          endcase
`ifdef MIO_BUSERR_EN
          if (clr_q) begin
            bus_err  <= 1'b0;
            err_addr <= 32'h0;
          end
`endif
        end
        ST_WAIT: begin
          // RAM data arrives the cycle after the strobe and is held there.
          if (wait_cnt == 4'h0 && !wr_q) begin
            bus.data_to_CPU <= (sel_q == SEL_RAM) ? ram_dout : rd_hold;
          end
          if (wait_cnt == WAIT_LAST) begin
            state         <= ST_READY;
            bus.MIO_ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'h1;
          end
        end
        ST_READY: begin
          state         <= ST_TURN;
          bus.MIO_ready <= 1'b0;
        end
        ST_TURN: begin
          state <= ST_IDLE;
        end
        default: begin
          state         <= ST_IDLE;
          bus.MIO_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mio_bus_responder.sv
// ============================================================================
// tb_mio_bus_responder : vector table, corner sequences and random traffic
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mio_bus_responder;

  localparam int RAM_AW  = 10;
  localparam int RAM_LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mio_bus_if bus ();

  logic              ram_en, ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_din, ram_dout;
  logic [15:0]       sw_in, led_out;
`ifdef MIO_BUSERR_EN
  logic              bus_err;
  logic [31:0]       err_addr;
`endif

  mio_bus_responder #(.RAM_AW(RAM_AW), .RAM_LAT(RAM_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .sw_in    (sw_in),
    .led_out  (led_out)
`ifdef MIO_BUSERR_EN
    ,
    .bus_err  (bus_err),
    .err_addr (err_addr)
`endif
  );

  // Synchronous block RAM seen by the responder
  logic [31:0] ram_arr [0:(1<<RAM_AW)-1];
  logic        ram_clr;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < (1<<RAM_AW); i++) ram_arr[i] <= 32'h0;
      ram_dout <= 32'h0;
    end else if (ram_en) begin
      if (ram_we) ram_arr[ram_addr] <= ram_din;
      ram_dout <= ram_arr[ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] mem_m [int];
  logic [31:0] data_m;
  logic [15:0] led_m;
  logic [31:0] cnt_base;
  int          cnt_cyc;
  int          last_ready;
  bit          err_m;
  logic [31:0] erra_m;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] sw;
    logic [31:0] exp_data;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    data_m     = 32'h0;
    led_m      = 16'h0;
    cnt_base   = 32'h0;
    cnt_cyc    = cyc;
    last_ready = -100;
    err_m      = 1'b0;
    erra_m     = 32'h0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ready"}, {31'h0, bus.MIO_ready}, 32'h0);
    check({tag, "_data"},  bus.data_to_CPU, 32'h0);
    check({tag, "_led"},   {16'h0, led_out}, 32'h0);
    check({tag, "_ramen"}, {30'h0, ram_en, ram_we}, 32'h0);
`ifdef MIO_BUSERR_EN
    check({tag, "_buserr"}, {31'h0, bus_err}, 32'h0);
    check({tag, "_erraddr"}, err_addr, 32'h0);
`endif
  endtask

  // Issue one request at the current negedge; hold=1 leaves it asserted
  // after MIO_ready so the caller can chain the next one back to back.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [15:0] sw, input bit hold);
    int          t_acc, en_cnt, w;
    bit          seen, en_we;
    logic [RAM_AW-1:0] en_addr;
    logic [3:0]  rg;

    sw_in             = sw;
    bus.CPU_MIO       = 1'b1;
    bus.MemWrite      = wr;
    bus.MemRead       = ~wr;
    bus.addr_bus      = a;
    bus.data_from_CPU = d;

    t_acc = cyc;
    if (last_ready + 2 > t_acc) t_acc = last_ready + 2;

    rg = a[31:28];
    w  = int'(a[RAM_AW+1:2]);
    if (rg == 4'h0) begin
      if (wr) mem_m[w] = d;
      else    data_m = mem_m.exists(w) ? mem_m[w] : 32'h0;
    end else if (rg == 4'hE) begin
      if (wr) led_m = d[15:0];
      else    data_m = {16'h0, sw};
    end else if (rg == 4'hF) begin
      if (wr) begin cnt_base = d; cnt_cyc = t_acc + 2; end
      else    data_m = cnt_base + 32'(t_acc + 1 - cnt_cyc);
    end else begin
      if (!wr) data_m = 32'h0;
      if (!err_m) begin err_m = 1'b1; erra_m = a; end
    end
    if (wr && a[31:2] == 30'h3800_0001) begin err_m = 1'b0; erra_m = 32'h0; end

    seen = 1'b0; en_cnt = 0; en_we = 1'b0; en_addr = '0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); @(negedge clk);
      if (ram_en) begin en_cnt++; en_addr = ram_addr; en_we = ram_we; end
      if (bus.MIO_ready) begin seen = 1'b1; break; end
    end
    if (!hold) begin
      bus.CPU_MIO  = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
    end

    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL timeout: MIO_ready got 0 expected 1 within 40 cycles for addr %h", a);
    end else begin
      check("latency", 32'(cyc), 32'(t_acc + 1 + RAM_LAT));
      check("data", bus.data_to_CPU, data_m);
      check("led", {16'h0, led_out}, {16'h0, led_m});
      if (rg == 4'h0) begin
        check("ram_en_count", 32'(en_cnt), 32'd1);
        check("ram_addr", 32'(en_addr), 32'(w));
        check("ram_we", {31'h0, en_we}, {31'h0, wr});
      end else begin
        check("ram_en_count", 32'(en_cnt), 32'd0);
      end
`ifdef MIO_BUSERR_EN
      check("bus_err", {31'h0, bus_err}, {31'h0, err_m});
      check("err_addr", err_addr, erra_m);
`endif
    end
    last_ready = cyc;

    if (!hold) begin
      @(posedge clk); @(negedge clk);
      check("ready_width", {31'h0, bus.MIO_ready}, 32'h0);
    end
  endtask

  initial begin
    int          r1, cnt;
    logic [31:0] r, a, d;
    bit          wr, hold;
    int          sel;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0000, 32'h0000_0000, 16'h0000};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         16'h0000, 32'hDEAD_BEEF, 16'h0000};
    vecs[2] = '{1'b1, 32'hE000_0000, 32'h1234_ABCD, 16'h0000, 32'hDEAD_BEEF, 16'hABCD};
    vecs[3] = '{1'b0, 32'hE000_0000, 32'h0,         16'h00F0, 32'h0000_00F0, 16'hABCD};
    vecs[4] = '{1'b0, 32'h5000_0000, 32'h0,         16'h0000, 32'h0000_0000, 16'hABCD};
    vecs[5] = '{1'b1, 32'h5000_0000, 32'h1111_1111, 16'h0000, 32'h0000_0000, 16'hABCD};
    vecs[6] = '{1'b0, 32'h0000_0013, 32'h0,         16'h0000, 32'hDEAD_BEEF, 16'hABCD};
    vecs[7] = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 16'h0000, 32'hDEAD_BEEF, 16'hABCD};
    vecs[8] = '{1'b0, 32'h0000_1FFC, 32'h0,         16'h0000, 32'hCAFE_F00D, 16'hABCD};
    vecs[9] = '{1'b0, 32'h0000_0020, 32'h0,         16'h0000, 32'h0000_0000, 16'hABCD};

    bus.CPU_MIO = 1'b0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    bus.addr_bus = 32'h0; bus.data_from_CPU = 32'h0;
    sw_in = 16'h0; ram_clr = 1'b1; reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ram_clr = 1'b0;
    reset_checks("por");
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 10; i++) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].sw, 1'b0);
      check($sformatf("tbl%0d_data", i), bus.data_to_CPU, vecs[i].exp_data);
      check($sformatf("tbl%0d_led", i), {16'h0, led_out}, {16'h0, vecs[i].exp_led});
    end

    // Counter load near the top, read back right after the earliest re-accept
    txn(1'b1, 32'hF000_0000, 32'hFFFF_FFFE, 16'h0, 1'b1);
    txn(1'b0, 32'hF000_0000, 32'h0, 16'h0, 1'b0);
    check("cnt_wrap", bus.data_to_CPU, 32'h0000_0002);

    // Back-to-back: READY to next READY is 2 turnaround + 3 request cycles
    txn(1'b0, 32'h0000_0010, 32'h0, 16'h0, 1'b1);
    r1 = last_ready;
    txn(1'b0, 32'hE000_0000, 32'h0, 16'h5A5A, 1'b0);
    check("b2b_gap", 32'(last_ready - r1), 32'd5);

    // CPU_MIO low must not start anything
    bus.CPU_MIO = 1'b0; bus.MemRead = 1'b1; bus.addr_bus = 32'h0000_0010;
    cnt = 0;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      if (bus.MIO_ready || ram_en) cnt++;
    end
    bus.MemRead = 1'b0;
    check("no_mio", 32'(cnt), 32'd0);

`ifdef MIO_BUSERR_EN
    txn(1'b0, 32'h5000_0000, 32'h0, 16'h0, 1'b0);
    txn(1'b1, 32'h6000_0000, 32'h0, 16'h0, 1'b0);
    check("err_first", err_addr, 32'h5000_0000);
    txn(1'b1, 32'hE000_0004, 32'h0000_0077, 16'h0, 1'b0);
    check("err_clr", {31'h0, bus_err}, 32'h0);
`endif

    // Reset while a RAM write sits in WAIT
    bus.CPU_MIO = 1'b1; bus.MemWrite = 1'b1; bus.MemRead = 1'b0;
    bus.addr_bus = 32'h0000_0040; bus.data_from_CPU = 32'h0000_0055;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    bus.CPU_MIO = 1'b0; bus.MemWrite = 1'b0;
    @(posedge clk); @(negedge clk);
    reset_checks("midrst");
    reset = 1'b0;
    model_reset();
    cnt = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (bus.MIO_ready || ram_we) cnt++;
    end
    check("post_rst_idle", 32'(cnt), 32'd0);
    txn(1'b1, 32'h0000_0040, 32'h0000_0055, 16'h0, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      r   = $urandom();
      sel = $urandom_range(0, 3);
      case (sel)
        0:       a = {4'h0, r[27:12], 6'b0, r[5:0]};
        1:       a = {4'hE, r[27:0]};
        2:       a = {4'hF, r[27:0]};
        default: a = {4'($urandom_range(1, 13)), r[27:0]};
      endcase
      wr   = 1'($urandom_range(0, 1));
      d    = $urandom();
      hold = ($urandom_range(0, 3) == 0);
      txn(wr, a, d, 16'($urandom()), hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.CPU_MIO = 1'b0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
